mmio_keypad: RTL and testbench
==============================

Name: mmio_keypad

Overview:
- Parametrised memory-mapped key input peripheral; successor to the single-register "last pressed key" logic in the snake peripheral block.
- Per key: 2-flop synchroniser, debouncer, press-edge detection.
- Key events are translated to 8-bit codes through a parameter map and buffered in a FIFO that the CPU drains over the 6502 bus.
- Sits on the CPU clock beside RAM/ROM/VGA decode; the parent muxes data_out when addr is in the window.

Parameters:
- NUM_KEYS, 4, number of key inputs (1..8).
- KEY_ACTIVE_LOW, 1, 1 = key input 0 means pressed (DE2 KEY style).
- DEBOUNCE_CYCLES, 16, consecutive stable synced cycles before the debounced state flips (2..65535).
- FIFO_DEPTH, 4, event FIFO entries; power of 2, 2..16.
- BASE_ADDR, 16'h4010, first address of the 4-byte register window.
- KEYMAP, 64'h0000_0000_6177_7364, byte i = code for key i (default key0 'd', key1 's', key2 'w', key3 'a').
- RESET_KEY, 8'h73, reset value of the LAST register.

Ports:
- clock  in  1  CPU clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- addr  in  16  CPU address.
- rw  in  1  1 = read, 0 = write.
- data_in  in  8  CPU write data.
- data_out  out  8  registered read data.
- keys  in  NUM_KEYS  raw asynchronous key inputs.
- event_pending  out  1  high while the FIFO is non-empty (intended for nirq).

Behaviour:
- Reset (synchronous, active-high; takes priority over everything):
  - data_out=0, event_pending=0.
  - FIFO empty, overflow=0, LAST=RESET_KEY.
  - All debounced states = released; counters = 0; pending bits = 0; synchronisers cleared to the released level.
- Sync and debounce, per key:
  - pressed_raw = keys[i] ^ KEY_ACTIVE_LOW, passed through 2 flops.
  - If synced value != debounced state: counter increments. When counter == DEBOUNCE_CYCLES-1, the state flips and the counter clears.
  - If synced value == debounced state: counter clears. Any bounce therefore restarts the count.
  - Input-to-flip latency = 2 + DEBOUNCE_CYCLES cycles.
- Events:
  - A debounced released->pressed flip sets pending[i].
  - Each cycle, the lowest-index set pending bit is pushed (at most one push per cycle) and that bit clears.
  - A key that re-presses while still pending stays pending once; no duplicate event.
- Push rules:
  - FIFO not full, or a pop occurs in the same cycle: write KEYMAP byte i and set LAST to that code.
  - FIFO full with no pop: drop the event, set overflow sticky, still update LAST.
- Register window (BASE_ADDR+n, n=0..3); accesses outside the window leave data_out unchanged and cause no side effects.
  - +0 STATUS
    - Read: {5'b0, full, overflow, nonempty}.
    - Write: data_in[1]=1 clears overflow; data_in[0]=1 flushes the FIFO (pending bits untouched).
  - +1 DATA
    - Read: returns the head code and pops. Empty read returns 8'h00 with no state change.
    - Write ignored.
  - +2 LAST
    - Read: LAST, non-destructive.
    - Write ignored.
  - +3 STATE
    - Read: debounced pressed bits, zero-extended to 8.
    - Write ignored.
- Timing:
  - Read data is registered: it appears on data_out at the edge that samples addr/rw, i.e. 1-cycle latency.
  - Each clock with addr==BASE+1 and rw=1 counts as exactly one pop.
- Simultaneous events:
  - Push and pop in the same cycle, FIFO full: both succeed; count unchanged; no overflow.
  - Push and pop in the same cycle, FIFO empty: the pop returns 8'h00; the push lands.
  - Flush write and push in the same cycle: flush wins, then the push is applied (FIFO ends with 1 entry).
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is log2(FIFO_DEPTH)+1 bits.
- event_pending = nonempty, registered with the FIFO state.

Optional Feature:
- Macro: MMIO_KEYPAD_RELEASE_EN.
- Defined:
  - Debounced pressed->released flips also set a separate release-pending bit.
  - Release events are arbitrated after all press-pending bits and pushed as KEYMAP byte | 8'h80.
  - Release events do not update LAST.
  - STATUS bit3 reads 1.
- Undefined:
  - Releases generate no events.
  - STATUS bit3 = 0.
  - No release-pending logic is synthesised.

Test Plan:
- Reset: read +2 -> 8'h73; read +0 -> 8'h00; event_pending=0.
- DEBOUNCE_CYCLES=4, key0 driven low for 3 cycles then high, repeated: no event, STATUS 8'h00. Then held low: STATE 8'h01 exactly 6 cycles after the stable edge; STATUS 8'h01; DATA 8'h64; STATUS 8'h00.
- key1 and key3 pressed in the same cycle: event_pending=1; DATA reads give 8'h73 then 8'h61; LAST = 8'h61.
- FIFO_DEPTH=4, five separate presses of key2 with no reads:
  - STATUS 8'h07.
  - Four DATA reads each give 8'h77; the fifth gives 8'h00.
  - Write 8'h02 to +0, then STATUS 8'h00.
- FIFO full, and a DATA read coincides with a new key0 push: the read returns the old head; STATUS stays 8'h05 (full, nonempty, no overflow); the last entry is 8'h64.
- With MMIO_KEYPAD_RELEASE_EN: press then release key0 -> DATA gives 8'h64 then 8'hE4; LAST = 8'h64; STATUS bit3 = 1.

Source files
------------

// File: rtl/mmio_keypad.sv
// mmio_keypad: memory-mapped key input peripheral for the 6502 bus.
// Per-key 2-flop synchroniser, debouncer and press-edge detection feed a
// code FIFO the CPU drains through a 4-byte register window at BASE_ADDR.
// Optional build macro MMIO_KEYPAD_RELEASE_EN: also queue release events
// (code | 8'h80, arbitrated after presses) and report it in STATUS bit3.
module mmio_keypad #(
  parameter int unsigned NUM_KEYS        = 4,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter logic [15:0] BASE_ADDR       = 16'h4010,
  parameter logic [63:0] KEYMAP          = 64'h0000_0000_6177_7364,
  parameter logic [7:0]  RESET_KEY       = 8'h73
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [15:0]         addr,
  input  logic                rw,
  input  logic [7:0]          data_in,
  output logic [7:0]          data_out,
  input  logic [NUM_KEYS-1:0] keys,
  output logic                event_pending
);

  localparam int unsigned PW     = $clog2(FIFO_DEPTH);
  localparam logic [15:0] CntMax = 16'(DEBOUNCE_CYCLES - 1);
`ifdef MMIO_KEYPAD_RELEASE_EN
  localparam logic RelBit = 1'b1;
`else
  localparam logic RelBit = 1'b0;
`endif

  logic [NUM_KEYS-1:0] r_sync1, r_sync2, r_state, r_pend;
  logic [15:0]         r_dcnt [NUM_KEYS];
  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [PW-1:0]       r_rptr, r_wptr;
  logic [PW:0]         r_cnt;
  logic                r_ovf;
  logic [7:0]          r_last;

  logic [NUM_KEYS-1:0] w_state_d, w_press, w_pend_d;
  logic [15:0]         w_dcnt_d [NUM_KEYS];
  logic [15:0]         w_off;
  logic                w_in_win, w_rd, w_pop, w_flush, w_ovf_clr, w_full, w_nonempty;
  logic                w_push_valid, w_is_rel, w_push_acc;
  logic [2:0]          w_idx;
  logic [7:0]          w_code, w_rdata, w_state8;
  logic [PW-1:0]       w_wr_ptr, w_rptr_d, w_wptr_d;
  logic [PW:0]         w_cnt_d;
  logic                w_unused;

  assign w_unused = ^data_in[7:2];

  // Bus decode; window need not be 4-byte aligned.
  assign w_off      = addr - BASE_ADDR;
  assign w_in_win   = (w_off[15:2] == 14'd0);
  assign w_rd       = w_in_win & rw;
  assign w_full     = (r_cnt == (PW + 1)'(FIFO_DEPTH));
  assign w_nonempty = (r_cnt != '0);
  assign w_pop      = w_rd & (w_off[1:0] == 2'd1) & w_nonempty;
  assign w_flush    = w_in_win & ~rw & (w_off[1:0] == 2'd0) & data_in[0];
  assign w_ovf_clr  = w_in_win & ~rw & (w_off[1:0] == 2'd0) & data_in[1];

  // Debounce: a mismatch must persist DEBOUNCE_CYCLES evaluations to flip.
  always_comb begin
    w_state_d = r_state;
    for (int i = 0; i < NUM_KEYS; i++) begin
      w_dcnt_d[i] = '0;
      if (r_sync2[i] != r_state[i]) begin
        if (r_dcnt[i] == CntMax) w_state_d[i] = ~r_state[i];
        else                     w_dcnt_d[i]  = r_dcnt[i] + 16'd1;
      end
    end
    w_press = w_state_d & ~r_state;
  end

`ifdef MMIO_KEYPAD_RELEASE_EN
  logic [NUM_KEYS-1:0] r_rel_pend, w_rel_pend_d;
`endif

  // Arbitration: lowest pending press first, then (optionally) releases.
  always_comb begin
    w_push_valid = 1'b0;
    w_is_rel     = 1'b0;
    w_idx        = 3'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_push_valid = 1'b1;
        w_idx        = 3'(i);
      end
    end
`ifdef MMIO_KEYPAD_RELEASE_EN
    if (!w_push_valid) begin
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
        if (r_rel_pend[i]) begin
          w_push_valid = 1'b1;
          w_is_rel     = 1'b1;
          w_idx        = 3'(i);
        end
      end
    end
    w_rel_pend_d = r_rel_pend | (~w_state_d & r_state);
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (w_push_valid && w_is_rel && (w_idx == 3'(i))) w_rel_pend_d[i] = 1'b0;
    end
`endif
    w_pend_d = r_pend;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (w_push_valid && !w_is_rel && (w_idx == 3'(i))) w_pend_d[i] = 1'b0;
    end
    // A new flip wins over the clear so no press is ever lost.
    w_pend_d = w_pend_d | w_press;
    w_code   = KEYMAP[{w_idx, 3'b000} +: 8] | {w_is_rel, 7'd0};
  end

  // FIFO next state: flush first, then pop/push on the resulting pointers.
  always_comb begin
    w_push_acc = w_push_valid & (w_flush | ~w_full | w_pop);
    w_wr_ptr   = w_flush ? '0 : r_wptr;
    w_rptr_d   = w_flush ? '0 : r_rptr;
    w_cnt_d    = w_flush ? '0 : r_cnt;
    w_wptr_d   = w_wr_ptr;
    if (w_pop) begin
      w_rptr_d = r_rptr + 1'b1;
      w_cnt_d  = w_cnt_d - 1'b1;
    end
    if (w_push_acc) begin
      w_wptr_d = w_wr_ptr + 1'b1;
      w_cnt_d  = w_cnt_d + 1'b1;
    end
  end

  // Register read mux.
  always_comb begin
    w_state8                = '0;
    w_state8[NUM_KEYS-1:0]  = r_state;
    w_rdata                 = '0;
    unique case (w_off[1:0])
      2'd0: w_rdata = {4'd0, RelBit, w_full, r_ovf, w_nonempty};
      2'd1: w_rdata = w_nonempty ? r_mem[r_rptr] : 8'h00;
      2'd2: w_rdata = r_last;
      2'd3: w_rdata = w_state8;
    endcase
  end

  // All control state with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1       <= '0;
      r_sync2       <= '0;
      r_state       <= '0;
      r_pend        <= '0;
      for (int i = 0; i < NUM_KEYS; i++) r_dcnt[i] <= '0;
      r_rptr        <= '0;
      r_wptr        <= '0;
      r_cnt         <= '0;
      r_ovf         <= 1'b0;
      r_last        <= RESET_KEY;
      data_out      <= 8'h00;
      event_pending <= 1'b0;
`ifdef MMIO_KEYPAD_RELEASE_EN
      r_rel_pend    <= '0;
`endif
    end else begin
      r_sync1       <= keys ^ {NUM_KEYS{KEY_ACTIVE_LOW}};
      r_sync2       <= r_sync1;
      r_state       <= w_state_d;
      r_pend        <= w_pend_d;
      for (int i = 0; i < NUM_KEYS; i++) r_dcnt[i] <= w_dcnt_d[i];
      r_rptr        <= w_rptr_d;
      r_wptr        <= w_wptr_d;
      r_cnt         <= w_cnt_d;
      // Clear then set, so a drop in the clearing cycle stays visible.
      r_ovf         <= (r_ovf & ~w_ovf_clr) | (w_push_valid & ~w_push_acc);
      if (w_push_valid && !w_is_rel) r_last <= w_code;
      if (w_rd) data_out <= w_rdata;
      event_pending <= (w_cnt_d != '0);
`ifdef MMIO_KEYPAD_RELEASE_EN
      r_rel_pend    <= w_rel_pend_d;
`endif
    end
  end

  // FIFO storage, no reset needed.
  always_ff @(posedge clock) begin
    if (!reset && w_push_acc) r_mem[w_wr_ptr] <= w_code;
  end

endmodule

// File: tb/tb_mmio_keypad.sv
// Scoreboard bench for mmio_keypad (NUM_KEYS=4, DEBOUNCE_CYCLES=4, FIFO_DEPTH=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_mmio_keypad;

  localparam logic [15:0] Base = 16'h4010;
`ifdef MMIO_KEYPAD_RELEASE_EN
  localparam logic [7:0] StRel = 8'h08;
`else
  localparam logic [7:0] StRel = 8'h00;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic        rw = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic [7:0]  data_out;
  logic [3:0]  keys = 4'hF;
  logic        event_pending;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  string      tag_q[$];

  mmio_keypad #(
    .NUM_KEYS(4), .KEY_ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4),
    .BASE_ADDR(Base), .KEYMAP(64'h0000_0000_6177_7364), .RESET_KEY(8'h73)
  ) u_dut (
    .clock(clock), .reset(reset), .addr(addr), .rw(rw), .data_in(data_in),
    .data_out(data_out), .keys(keys), .event_pending(event_pending)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One read cycle: expectation queued at issue, checked when data_out updates.
  task automatic rd(input logic [1:0] off, input logic [7:0] exp, input string tag);
    addr = Base + 16'(off);
    rw   = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    tick();
    addr = 16'h0000;
    check_eq(tag_q.pop_front(), data_out, exp_q.pop_front());
  endtask

  task automatic wr(input logic [1:0] off, input logic [7:0] d);
    addr    = Base + 16'(off);
    rw      = 1'b0;
    data_in = d;
    tick();
    rw      = 1'b1;
    addr    = 16'h0000;
  endtask

  // Full press/release of one key; each debounced flip lands 6 edges after the change.
  task automatic tap(input int k);
    keys[k] = 1'b0;
    idle(8);
    keys[k] = 1'b1;
    idle(8);
  endtask

  initial begin
    idle(3);
    check_eq("rst_data_out", data_out, 8'h00);
    check_eq("rst_evt", {7'd0, event_pending}, 8'h00);
    reset = 1'b0;
    rd(2'd2, 8'h73, "rst_last");
    rd(2'd0, 8'h00 | StRel, "rst_status");
    check_eq("rst_evt_after", {7'd0, event_pending}, 8'h00);

`ifdef MMIO_KEYPAD_RELEASE_EN
    tap(0);
    rd(2'd1, 8'h64, "rel_press_code");
    rd(2'd1, 8'hE4, "rel_release_code");
    rd(2'd2, 8'h64, "rel_last");
    rd(2'd0, 8'h08, "rel_status");
`else
    // Bounce: 3 low cycles never reach the 4-cycle threshold.
    for (int r = 0; r < 3; r++) begin
      keys[0] = 1'b0;
      idle(3);
      keys[0] = 1'b1;
      idle(3);
    end
    idle(6);
    rd(2'd0, 8'h00, "bounce_status");
    rd(2'd3, 8'h00, "bounce_state");

    // Stable press: state flips at edge 6, visible in the read sampled at edge 7.
    keys[0] = 1'b0;
    for (int k = 1; k <= 7; k++) rd(2'd3, (k == 7) ? 8'h01 : 8'h00, $sformatf("state_e%0d", k));
    check_eq("press_evt", {7'd0, event_pending}, 8'h01);
    rd(2'd0, 8'h01, "press_status");
    rd(2'd1, 8'h64, "press_data");
    rd(2'd0, 8'h00, "press_status_empty");
    keys[0] = 1'b1;
    idle(8);

    // Simultaneous key1/key3: lower index first.
    keys[1] = 1'b0;
    keys[3] = 1'b0;
    idle(8);
    check_eq("dual_evt", {7'd0, event_pending}, 8'h01);
    rd(2'd1, 8'h73, "dual_first");
    rd(2'd1, 8'h61, "dual_second");
    rd(2'd2, 8'h61, "dual_last");
    keys[1] = 1'b1;
    keys[3] = 1'b1;
    idle(8);

    // Overflow: five key2 presses into a 4-deep FIFO.
    for (int r = 0; r < 5; r++) tap(2);
    rd(2'd0, 8'h07, "ovf_status");
    for (int r = 0; r < 4; r++) rd(2'd1, 8'h77, $sformatf("ovf_data%0d", r));
    rd(2'd1, 8'h00, "ovf_empty_read");
    rd(2'd0, 8'h02, "ovf_sticky");
    wr(2'd0, 8'h02);
    rd(2'd0, 8'h00, "ovf_cleared");

    // Full FIFO: a DATA read coincides with the key0 push at edge 7.
    for (int r = 0; r < 4; r++) tap(2);
    keys[0] = 1'b0;
    idle(6);
    rd(2'd1, 8'h77, "coinc_head");
    rd(2'd0, 8'h05, "coinc_status");
    for (int r = 0; r < 3; r++) rd(2'd1, 8'h77, $sformatf("coinc_drain%0d", r));
    rd(2'd1, 8'h64, "coinc_tail");
    rd(2'd0, 8'h00, "coinc_empty");
    rd(2'd2, 8'h64, "coinc_last");
    keys[0] = 1'b1;
    idle(8);

    // Out-of-window read and LAST write leave things untouched.
    addr = Base + 16'd4;
    tick();
    addr = 16'h0000;
    check_eq("outwin_hold", data_out, 8'h64);
    wr(2'd2, 8'h11);
    rd(2'd2, 8'h64, "last_write_ignored");

    // Flush discards queued codes.
    tap(2);
    tap(1);
    wr(2'd0, 8'h01);
    rd(2'd0, 8'h00, "flush_status");
    rd(2'd1, 8'h00, "flush_data");
    check_eq("flush_evt", {7'd0, event_pending}, 8'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
